// File: rtl/hs_unit_pkg.sv
// Shared definitions for the hs_unit handshake blocks.
//   skid_state_e : fill state of the two-entry skid buffer
//   SKID_DEPTH   : number of payload entries held by the skid buffer
//   skid_occ     : maps a fill state to its entry count
package hs_unit_pkg;

  typedef enum logic [1:0] {SKID_EMPTY, SKID_BUSY, SKID_FULL} skid_state_e;

  localparam int SKID_DEPTH = 2;

  // Entry count held in a given fill state.
  function automatic logic [1:0] skid_occ(input skid_state_e st);
    logic [1:0] occ;
    case (st)
      SKID_EMPTY: occ = 2'd0;
      SKID_BUSY:  occ = 2'd1;
      SKID_FULL:  occ = 2'(SKID_DEPTH);
      default:    occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/hs_unit_dff_noreset_ce.sv
// Clock-enabled data register without reset.
//   clk : clock
//   ce  : load enable; q takes d on a rising edge with ce high
//   d   : next payload
//   q   : held payload (undefined until first load)
module hs_unit_dff_noreset_ce #(
  parameter type DATA_TYPE = logic
) (
  input  logic     clk,
  input  logic     ce,
  input  DATA_TYPE d,
  output DATA_TYPE q
);

  // Payload storage; only the enable can change it.
  always_ff @(posedge clk) begin
    if (ce) begin
      q <= d;
    end
  end

endmodule

// File: rtl/hs_unit_skid_buffer.sv
// Two-entry valid/ready skid buffer with fully registered outputs.
// Sustains one transfer per cycle and breaks the combinational ready path:
// s_ready and m_valid depend only on registers.
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   s_valid   : upstream payload valid
//   s_ready   : buffer can accept (registered)
//   s_data    : upstream payload
//   m_valid   : output payload valid (registered)
//   m_ready   : downstream accepts
//   m_data    : output payload, straight from the main register
//   occupancy : entries held, 0..2
module hs_unit_skid_buffer
  import hs_unit_pkg::*;
#(
  parameter type DATA_TYPE = logic
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s_valid,
  output logic       s_ready,
  input  DATA_TYPE   s_data,
  output logic       m_valid,
  input  logic       m_ready,
  output DATA_TYPE   m_data,
  output logic [1:0] occupancy
);

  skid_state_e state_r;
  skid_state_e state_nxt_s;
  logic        s_ready_r;
  logic [1:0]  occupancy_r;
  logic        s_fire_s;
  logic        main_ce_s;
  logic        skid_ce_s;
  DATA_TYPE    main_d_s;
  DATA_TYPE    skid_q_s;

  assign s_fire_s  = s_valid & s_ready_r;
  assign s_ready   = s_ready_r;
  assign occupancy = occupancy_r;
  // Pure decode of the state register, so no path from s_valid.
  assign m_valid   = (state_r != SKID_EMPTY);

  // Next-state and data-register load enables.
  always_comb begin
    state_nxt_s = state_r;
    main_ce_s   = 1'b0;
    skid_ce_s   = 1'b0;
    main_d_s    = s_data;
    case (state_r)
      SKID_EMPTY: begin
        if (s_fire_s) begin
          main_ce_s   = 1'b1;
          state_nxt_s = SKID_BUSY;
        end else begin
          state_nxt_s = SKID_EMPTY;
        end
      end
      SKID_BUSY: begin
        if (s_fire_s && m_ready) begin
          main_ce_s   = 1'b1;
          state_nxt_s = SKID_BUSY;
        end else if (s_fire_s) begin
          // Downstream stalled: the in-flight word goes to the skid.
          skid_ce_s   = 1'b1;
          state_nxt_s = SKID_FULL;
        end else if (m_ready) begin
          state_nxt_s = SKID_EMPTY;
        end else begin
          state_nxt_s = SKID_BUSY;
        end
      end
      SKID_FULL: begin
        main_d_s = skid_q_s;
        if (m_ready) begin
          main_ce_s   = 1'b1;
          state_nxt_s = SKID_BUSY;
        end else begin
          state_nxt_s = SKID_FULL;
        end
      end
      default: begin
        state_nxt_s = SKID_EMPTY;
      end
    endcase
    // A reset edge completes no transfer, so nothing is loaded either.
    if (rst) begin
      main_ce_s = 1'b0;
      skid_ce_s = 1'b0;
    end else begin
      main_ce_s = main_ce_s;
      skid_ce_s = skid_ce_s;
    end
  end

  // State, registered ready flag and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= SKID_EMPTY;
      s_ready_r   <= 1'b0;
      occupancy_r <= 2'd0;
    end else begin
      state_r     <= state_nxt_s;
      s_ready_r   <= (state_nxt_s != SKID_FULL);
      occupancy_r <= skid_occ(state_nxt_s);
    end
  end

  hs_unit_dff_noreset_ce #(.DATA_TYPE(DATA_TYPE)) u_main (
    .clk (clk),
    .ce  (main_ce_s),
    .d   (main_d_s),
    .q   (m_data)
  );

  hs_unit_dff_noreset_ce #(.DATA_TYPE(DATA_TYPE)) u_skid (
    .clk (clk),
    .ce  (skid_ce_s),
    .d   (s_data),
    .q   (skid_q_s)
  );

endmodule

// File: tb/tb_hs_unit_skid_buffer.sv
// Self-checking bench for hs_unit_skid_buffer with an 8-bit payload.
// The reference is a plain FIFO queue of at most two words.
module tb_hs_unit_skid_buffer;

  logic       clk;
  logic       rst;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic [1:0] occupancy;

  int checks;
  int passed;

  logic [7:0] mq[$];
  logic       exp_s_ready;

  hs_unit_skid_buffer #(.DATA_TYPE(logic [7:0])) dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Compare every DUT output against the queue model.
  task automatic compare_model();
    chk("m_valid", 32'(m_valid), 32'(mq.size() > 0));
    chk("occupancy", 32'(occupancy), 32'(mq.size()));
    chk("s_ready", 32'(s_ready), 32'(exp_s_ready));
    if (mq.size() > 0) chk("m_data", 32'(m_data), 32'(mq[0]));
  endtask

  // One clock: drive inputs, advance the model across the edge, then check.
  task automatic cycle(input logic r, input logic sv, input logic [7:0] sd, input logic mr);
    logic sf;
    logic mf;
    rst = r; s_valid = sv; s_data = sd; m_ready = mr;
    sf = sv & exp_s_ready;
    mf = (mq.size() > 0) & mr;
    @(posedge clk);
    if (r) begin
      mq.delete();
      exp_s_ready = 1'b0;
    end else begin
      if (mf) void'(mq.pop_front());
      if (sf) mq.push_back(sd);
      exp_s_ready = (mq.size() < 2);
    end
    #1;
    compare_model();
  endtask

  // Wiggle the inputs mid-cycle; registered outputs must not move.
  task automatic comb_probe();
    logic sr0, mv0, sv0, mr0;
    sr0 = s_ready; mv0 = m_valid; sv0 = s_valid; mr0 = m_ready;
    m_ready = ~mr0; s_valid = ~sv0;
    #1;
    chk("comb_s_ready", 32'(s_ready), 32'(sr0));
    chk("comb_m_valid", 32'(m_valid), 32'(mv0));
    m_ready = mr0; s_valid = sv0;
  endtask

  initial begin
    checks = 0; passed = 0;
    exp_s_ready = 1'b0;
    rst = 1'b1; s_valid = 1'b0; s_data = 8'h00; m_ready = 1'b0;

    // Reset held three cycles with a valid word offered.
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, 8'hAA, 1'b0);
      chk("rst_m_valid", 32'(m_valid), 32'd0);
      chk("rst_s_ready", 32'(s_ready), 32'd0);
      chk("rst_occ", 32'(occupancy), 32'd0);
    end
    cycle(1'b0, 1'b1, 8'hAA, 1'b0);
    chk("release_s_ready", 32'(s_ready), 32'd1);
    chk("release_m_valid", 32'(m_valid), 32'd0);

    // Back-to-back streaming 01..10.
    for (int k = 1; k <= 16; k++) begin
      cycle(1'b0, 1'b1, 8'(k), 1'b1);
      chk("stream_data", 32'(m_data), 32'(k));
      chk("stream_occ", 32'(occupancy), 32'd1);
    end
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    chk("stream_drained", 32'(m_valid), 32'd0);

    // Skid absorbs 21 while downstream stalls.
    cycle(1'b0, 1'b1, 8'h20, 1'b1);
    cycle(1'b0, 1'b1, 8'h21, 1'b0);
    chk("skid_occ", 32'(occupancy), 32'd2);
    chk("skid_s_ready", 32'(s_ready), 32'd0);
    chk("skid_hold", 32'(m_data), 32'h20);
    cycle(1'b0, 1'b1, 8'h22, 1'b0);
    chk("skid_stable", 32'(m_data), 32'h20);
    cycle(1'b0, 1'b1, 8'h22, 1'b1);
    chk("skid_out21", 32'(m_data), 32'h21);
    chk("skid_recover", 32'(s_ready), 32'd1);
    cycle(1'b0, 1'b1, 8'h22, 1'b1);
    chk("skid_out22", 32'(m_data), 32'h22);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    chk("skid_empty", 32'(occupancy), 32'd0);

    // Random traffic against the queue model.
    for (int i = 0; i < 1000; i++) begin
      s_valid = 1'($urandom_range(0, 1));
      m_ready = 1'($urandom_range(0, 1));
      if (i % 16 == 0) comb_probe();
      cycle(1'b0, s_valid, 8'($urandom), m_ready);
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1);

    // Reset while FULL discards everything.
    cycle(1'b0, 1'b1, 8'h30, 1'b0);
    cycle(1'b0, 1'b1, 8'h31, 1'b0);
    chk("full_occ", 32'(occupancy), 32'd2);
    cycle(1'b1, 1'b1, 8'h99, 1'b1);
    chk("midrst_m_valid", 32'(m_valid), 32'd0);
    chk("midrst_occ", 32'(occupancy), 32'd0);
    cycle(1'b0, 1'b0, 8'h00, 1'b0);
    cycle(1'b0, 1'b1, 8'h40, 1'b0);
    chk("first_after_rst", 32'(m_data), 32'h40);
    chk("first_after_rst_occ", 32'(occupancy), 32'd1);

    // Drain to empty.
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    cycle(1'b0, 1'b1, 8'h50, 1'b0);
    chk("drain_busy", 32'(m_data), 32'h50);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    chk("drain_m_valid", 32'(m_valid), 32'd0);
    chk("drain_occ", 32'(occupancy), 32'd0);
    chk("drain_s_ready", 32'(s_ready), 32'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
